booth_skip_ctrl: RTL and testbench

- Sequential controller for the 16-bit signed radix-2 Booth multiplier with run skipping.
- Owns the A/Q/q_1/M registers and the iteration FSM. Each cycle it asks the run detector for the length of the current run of equal recoding bits, then either shifts across that whole run or does one add/sub-and-shift.
- Sits between the top-level start/done handshake and the multiplier datapath.

---
 rtl/booth_skip_ctrl_pkg.sv | 17 +
 rtl/shift_amount.sv | 24 ++
 rtl/booth_skip_ctrl.sv | 141 ++++++++++++++
 tb/tb_booth_skip_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_skip_ctrl_pkg.sv
// Shared definitions for the run-skipping radix-2 Booth multiplier controller.
// Holds the operand width, FSM state encoding and Booth pair codes.
package booth_skip_ctrl_pkg;

    localparam int WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_t;

    // {Q[0], q_1} recoding pairs
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/shift_amount.sv
// Run detector: counts how many further bits above number[0] repeat number[0],
// i.e. how many Booth pairs in a row need no add/sub. Saturates at 15.
module shift_amount (
    input  logic [16:0] number,
    output logic [4:0]  amt
);

    logic run_on;

    always_comb begin
        amt    = 5'd0;
        run_on = 1'b1;
        for (int i = 1; i < 17; i++) begin
            if (run_on && (number[i] == number[0])) begin
                if (amt < 5'd15) begin
                    amt = amt + 5'd1;
                end
            end else begin
                run_on = 1'b0;
            end
        end
    end

endmodule

// File: rtl/booth_skip_ctrl.sv
// Sequential radix-2 Booth multiplier controller with run skipping.
// Owns A/Q/q_1/M, the remaining-bit counter and the iteration FSM.
//
//   state | meaning
//   IDLE  | waiting for start; operands captured when start is seen
//   EVAL  | one Booth step or one multi-bit run skip per cycle
//   DONE  | one-cycle done pulse, product valid
module booth_skip_ctrl
    import booth_skip_ctrl_pkg::state_t;
    import booth_skip_ctrl_pkg::IDLE;
    import booth_skip_ctrl_pkg::EVAL;
    import booth_skip_ctrl_pkg::DONE;
    import booth_skip_ctrl_pkg::BOOTH_ADD;
    import booth_skip_ctrl_pkg::BOOTH_SUB;
#(
    parameter int WIDTH = booth_skip_ctrl_pkg::WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [4:0]           step_count
);

    localparam int VW = 2*WIDTH + 2;

    state_t state, state_next;

    logic [WIDTH:0]   a_reg;
    logic [WIDTH-1:0] q_reg;
    logic             q_1;
    logic [WIDTH-1:0] m_reg;
    logic [4:0]       rem;

    logic [4:0]       amt;
    logic [4:0]       shift_k;
    logic [1:0]       pair;
    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   a_pre;
    logic [VW-1:0]    shifted;
    logic [WIDTH:0]   a_next;
    logic [WIDTH-1:0] q_next;
    logic             q_1_next;
    logic [4:0]       rem_next;

    shift_amount u_shift_amount (
        .number ({q_reg, q_1}),
        .amt    (amt)
    );

    always_comb begin
        pair    = {q_reg[0], q_1};
        m_ext   = {m_reg[WIDTH-1], m_reg};
        a_pre   = a_reg;
        shift_k = 5'd1;
        if (amt == 5'd0) begin
            if (pair == BOOTH_SUB) begin
                a_pre = a_reg - m_ext;
            end else if (pair == BOOTH_ADD) begin
                a_pre = a_reg + m_ext;
            end
        end else begin
            // never shift past the bits still owed, so a saturated run cannot overshoot
            shift_k = (amt < rem) ? amt : rem;
        end
        shifted  = $signed({a_pre, q_reg, q_1}) >>> shift_k;
        a_next   = shifted[VW-1:WIDTH+1];
        q_next   = shifted[WIDTH:1];
        q_1_next = shifted[0];
        rem_next = rem - shift_k;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = EVAL;
            EVAL:    if (rem_next == 5'd0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            EVAL:    busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg      <= '0;
            q_reg      <= '0;
            q_1        <= 1'b0;
            m_reg      <= '0;
            rem        <= 5'd0;
            step_count <= 5'd0;
            product    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg      <= '0;
                        q_reg      <= multiplier;
                        q_1        <= 1'b0;
                        m_reg      <= multiplicand;
                        rem        <= 5'(WIDTH);
                        step_count <= 5'd0;
                    end
                end
                EVAL: begin
                    a_reg      <= a_next;
                    q_reg      <= q_next;
                    q_1        <= q_1_next;
                    rem        <= rem_next;
                    step_count <= step_count + 5'd1;
                    if (rem_next == 5'd0) begin
                        product <= {a_next[WIDTH-1:0], q_next};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_skip_ctrl.sv
// Self-checking bench for booth_skip_ctrl: directed cases, start-ignore,
// async abort and a random sweep against a plain signed-multiply model.
module tb_booth_skip_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] multiplicand;
    logic [15:0] multiplier;
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic [4:0]  step_count;

    int n_checks = 0;
    int n_fail   = 0;

    booth_skip_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .step_count   (step_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mul(input logic [15:0] m, input logic [15:0] q);
        logic signed [31:0] r;
        r = $signed(m) * $signed(q);
        return r;
    endfunction

    // Issue one multiply; returns the product and step_count seen in the done cycle.
    task automatic run_op(input logic [15:0] m, input logic [15:0] q, input bit pulse_mid,
                          output logic [31:0] p, output int steps, output int bcyc,
                          output bit ok);
        bit seen;
        ok    = 1'b0;
        seen  = 1'b0;
        bcyc  = 0;
        steps = -1;
        p     = 'x;
        @(negedge clk);
        start        = 1'b1;
        multiplicand = m;
        multiplier   = q;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(posedge clk); #1;
            if (busy) seen = 1'b1;
        end
        start = 1'b0;
        if (!seen) return;
        bcyc = 1;
        for (int i = 0; i < 40; i++) begin
            if (pulse_mid && i == 2) start = 1'b1;
            else start = 1'b0;
            @(posedge clk); #1;
            if (done) begin
                p     = product;
                steps = int'(step_count);
                ok    = 1'b1;
                break;
            end
            if (busy) bcyc++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++;
        if (product !== 32'h0) begin n_fail++; $display("FAIL reset_product got %h want 0", product); end
        n_checks++;
        if (step_count !== 5'd0) begin n_fail++; $display("FAIL reset_steps got %0d want 0", step_count); end
    endtask

    task automatic test_directed;
        logic [15:0] tm [5] = '{16'd3, 16'h1234, 16'h8000, 16'd7, 16'd3};
        logic [15:0] tq [5] = '{16'd5, 16'h0000, 16'h8000, 16'h5555, 16'hFFFF};
        logic [31:0] tp [5] = '{32'h0000000F, 32'h0, 32'h40000000, 32'h00025553, 32'hFFFFFFFD};
        int          ts [5] = '{5, 2, 2, 16, 2};
        logic [31:0] p;
        int steps, bcyc;
        bit ok;
        for (int i = 0; i < 5; i++) begin
            run_op(tm[i], tq[i], 1'b0, p, steps, bcyc, ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL dir%0d_timeout got no done want done pulse", i);
                continue;
            end
            n_checks++;
            if (p !== tp[i] || p !== ref_mul(tm[i], tq[i])) begin
                n_fail++;
                $display("FAIL dir%0d_product got %h want %h", i, p, tp[i]);
            end
            n_checks++;
            if (steps != ts[i]) begin
                n_fail++;
                $display("FAIL dir%0d_steps got %0d want %0d", i, steps, ts[i]);
            end
            n_checks++;
            if (bcyc != ts[i]) begin
                n_fail++;
                $display("FAIL dir%0d_busy_cycles got %0d want %0d", i, bcyc, ts[i]);
            end
            @(posedge clk); #1;
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL dir%0d_after_done got done=%b busy=%b want 0 0", i, done, busy);
            end
            n_checks++;
            if (product !== tp[i]) begin
                n_fail++;
                $display("FAIL dir%0d_hold got %h want %h", i, product, tp[i]);
            end
        end
    endtask

    task automatic test_start_ignore;
        logic [31:0] p;
        int steps, bcyc;
        bit ok, relaunched;
        run_op(16'd3, 16'd5, 1'b1, p, steps, bcyc, ok);
        n_checks++;
        if (!ok || p !== ref_mul(16'd3, 16'd5) || steps != 5) begin
            n_fail++;
            $display("FAIL ignore_result got ok=%0b p=%h steps=%0d want 1 %h 5", ok, p, steps,
                     ref_mul(16'd3, 16'd5));
        end
        relaunched = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (busy) relaunched = 1'b1;
        end
        n_checks++;
        if (relaunched) begin
            n_fail++;
            $display("FAIL ignore_not_queued got busy after done want idle");
        end
    endtask

    task automatic test_abort;
        logic [31:0] p;
        int steps, bcyc;
        bit ok, seen, saw_done;
        @(negedge clk);
        start        = 1'b1;
        multiplicand = 16'd7;
        multiplier   = 16'h5555;
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(posedge clk); #1;
            if (busy) seen = 1'b1;
        end
        start = 1'b0;
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL abort_busy got 0 want 1"); end
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_flags got busy=%b done=%b want 0 0", busy, done);
        end
        n_checks++;
        if (product !== 32'h0 || step_count !== 5'd0) begin
            n_fail++;
            $display("FAIL abort_regs got p=%h steps=%0d want 0 0", product, step_count);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done) begin n_fail++; $display("FAIL abort_no_done got activity want none"); end
        run_op(16'd2, 16'd2, 1'b0, p, steps, bcyc, ok);
        n_checks++;
        if (!ok || p !== 32'd4) begin
            n_fail++;
            $display("FAIL abort_restart got ok=%0b p=%h want 1 00000004", ok, p);
        end
    endtask

    task automatic test_random;
        logic [15:0] m, q;
        logic [31:0] p, exp_p;
        int steps, bcyc;
        bit ok;
        for (int n = 0; n < 1000; n++) begin
            m = 16'($urandom);
            q = 16'($urandom);
            if (n % 8 == 0) q = {16{q[0]}};
            exp_p = ref_mul(m, q);
            run_op(m, q, 1'b0, p, steps, bcyc, ok);
            n_checks++;
            if (!ok || p !== exp_p) begin
                n_fail++;
                $display("FAIL rand_product m=%h q=%h got %h want %h", m, q, p, exp_p);
            end
            n_checks++;
            if (steps < 2 || steps > 16 || bcyc != steps) begin
                n_fail++;
                $display("FAIL rand_steps m=%h q=%h got %0d busy=%0d want 2..16 equal", m, q,
                         steps, bcyc);
            end
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_directed();
        test_start_ignore();
        test_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
